// File: rtl/tone_burst_generator.sv
// Square-wave tone source gated into counted ON/OFF beeps on a ms-style tick.
// Configured over valid/ready while idle; started and aborted by its controller.
module tone_burst_generator #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned DEFAULT_HZ = 440,
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned TICK_W     = 16,
  parameter int unsigned BEEP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_half_period,
  input  logic [TICK_W-1:0] cfg_on_ticks,
  input  logic [TICK_W-1:0] cfg_off_ticks,
  input  logic [BEEP_W-1:0] cfg_beeps,
  input  logic              start,
  input  logic              stop,
  output logic              tone_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(PRESCALE - 1);
  localparam logic [DIV_W-1:0] HP_RST =
    DIV_W'(CLK_HZ / (2 * DEFAULT_HZ));

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  hp_q;
  logic [DIV_W-1:0]  phase_q;
  logic [TICK_W-1:0] on_q;
  logic [TICK_W-1:0] off_q;
  logic [TICK_W-1:0] tick_q;
  logic [BEEP_W-1:0] beeps_q;
  logic [BEEP_W-1:0] left_q;
  logic [PRE_W-1:0]  pre_q;
  logic              tone_q;
  logic              busy_q;
  logic              done_q;

  logic              cfg_load;
  logic [DIV_W-1:0]  hp_last;
  logic [TICK_W-1:0] on_last;
  logic [TICK_W-1:0] off_last;
  logic [BEEP_W-1:0] left_d;
  logic [BEEP_W-1:0] beeps_d;
  logic              phase_wrap;
  logic              tick_wrap;
  logic              on_end;
  logic              off_end;
  logic              last_beep;

  assign cfg_load = cfg_valid && (state_q == IDLE);

  // Zero half-period and zero on-length both behave as one.
  assign hp_last = (hp_q == '0) ? '0
                 : hp_q - DIV_W'(1);
  assign on_last = (on_q == '0) ? '0
                 : on_q - TICK_W'(1);
  assign off_last = off_q - TICK_W'(1);

  assign phase_wrap = (phase_q == hp_last);
  assign tick_wrap  = (pre_q == PRE_LAST);
  assign on_end     = tick_wrap && (tick_q == on_last);
  assign off_end    = tick_wrap && (tick_q == off_last);

  assign left_d    = left_q - BEEP_W'(1);
  assign last_beep = (left_q != '0) && (left_d == '0);
  assign beeps_d   = cfg_load ? cfg_beeps : beeps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hp_q    <= HP_RST;
      on_q    <= TICK_W'(1);
      off_q   <= '0;
      beeps_q <= BEEP_W'(1);
      phase_q <= '0;
      tick_q  <= '0;
      pre_q   <= '0;
      left_q  <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cfg_load) begin
        hp_q    <= cfg_half_period;
        on_q    <= cfg_on_ticks;
        off_q   <= cfg_off_ticks;
        beeps_q <= cfg_beeps;
      end
      if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        tone_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            tone_q <= 1'b0;
            if (start) begin
              state_q <= ON;
              busy_q  <= 1'b1;
              phase_q <= '0;
              pre_q   <= '0;
              tick_q  <= '0;
              left_q  <= beeps_d;
            end
          end
          ON: begin
            pre_q <= tick_wrap ? '0
                   : pre_q + PRE_W'(1);
            if (tick_wrap) begin
              tick_q <= tick_q + TICK_W'(1);
            end
            if (phase_wrap) begin
              phase_q <= '0;
              tone_q  <= ~tone_q;
            end else begin
              phase_q <= phase_q + DIV_W'(1);
            end
            // Window end overrides the toggle so no high level leaks out.
            if (on_end) begin
              phase_q <= '0;
              pre_q   <= '0;
              tick_q  <= '0;
              tone_q  <= 1'b0;
              if (last_beep) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                left_q  <= '0;
              end else begin
                if (left_q != '0) begin
                  left_q <= left_d;
                end
                state_q <= (off_q == '0) ? ON : OFF;
              end
            end
          end
          OFF: begin
            tone_q <= 1'b0;
            pre_q  <= tick_wrap ? '0
                    : pre_q + PRE_W'(1);
            if (tick_wrap) begin
              tick_q <= tick_q + TICK_W'(1);
            end
            if (off_end) begin
              state_q <= ON;
              phase_q <= '0;
              pre_q   <= '0;
              tick_q  <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign tone_out  = tone_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tone_burst_generator.sv
// Bench for tone_burst_generator: table vectors, random bursts, corner sequences.
// Expected waveforms come from a window model of the beep schedule.
module tb_tone_burst_generator;

  localparam int P = 10;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_half_period;
  logic [15:0] cfg_on_ticks;
  logic [15:0] cfg_off_ticks;
  logic [7:0]  cfg_beeps;
  logic        start;
  logic        stop;
  logic        tone_out;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  tone_burst_generator #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .DEFAULT_HZ (440),
    .DIV_W      (24),
    .TICK_W     (16),
    .BEEP_W     (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_half_period (cfg_half_period),
    .cfg_on_ticks    (cfg_on_ticks),
    .cfg_off_ticks   (cfg_off_ticks),
    .cfg_beeps       (cfg_beeps),
    .start           (start),
    .stop            (stop),
    .tone_out        (tone_out),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hp;
    int on;
    int off;
    int nb;
    int exp_busy;
    int exp_rises;
    int exp_dones;
  } vec_t;

  task automatic check(input string name, input int act,
                       input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Tone at cycle k after entering ON: repeating ON/OFF windows,
  // square wave restarting low at every ON window.
  function automatic int model_tone(input int k, input int hp_e,
                                    input int on_e, input int off_e);
    int per;
    int pos;
    per = P * (on_e + off_e);
    pos = k % per;
    if (pos >= P * on_e) return 0;
    return (pos / hp_e) % 2;
  endfunction

  task automatic start_burst(input bit load, input int hp,
                             input int on, input int off,
                             input int nb);
    cfg_half_period = 24'(hp);
    cfg_on_ticks    = 16'(on);
    cfg_off_ticks   = 16'(off);
    cfg_beeps       = 8'(nb);
    cfg_valid       = load;
    start           = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic watch(input int hp_e, input int on_e,
                       input int off_e, input int nb,
                       input int limit, input int poke,
                       output int busy_n, output int rises,
                       output int dones);
    int len;
    int prev;
    len = (nb == 0) ? limit
        : P * (nb * on_e + (nb - 1) * off_e);
    busy_n = 0;
    rises  = 0;
    dones  = 0;
    prev   = 0;
    for (int k = 0; k < len; k++) begin
      check("tone", int'(tone_out),
            model_tone(k, hp_e, on_e, off_e));
      check("busy", int'(busy), 1);
      check("done_early", int'(done), 0);
      if (k == 0) check("ready_run", int'(cfg_ready), 0);
      busy_n += int'(busy);
      dones  += int'(done);
      if (tone_out && prev == 0) rises++;
      prev = int'(tone_out);
      if (k == poke) begin
        check("ready_poke", int'(cfg_ready), 0);
        cfg_half_period = 24'd7;
        cfg_on_ticks    = 16'd3;
        cfg_off_ticks   = 16'd3;
        cfg_beeps       = 8'd4;
        cfg_valid       = 1'b1;
        start           = 1'b1;
      end else begin
        cfg_valid = 1'b0;
        start     = 1'b0;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    if (nb != 0) begin
      check("end_busy", int'(busy), 0);
      check("end_done", int'(done), 1);
      check("end_tone", int'(tone_out), 0);
      dones += int'(done);
      @(negedge clk);
      check("done_pulse", int'(done), 0);
      dones += int'(done);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int bn;
    int rs;
    int dn;
    int hp;
    int on;
    int off;
    int nb;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{2, 2, 1, 1, 20, 5, 1};
    vecs[1] = '{3, 1, 2, 3, 70, 6, 1};
    vecs[2] = '{0, 1, 0, 2, 20, 10, 1};
    vecs[3] = '{5, 0, 0, 1, 10, 1, 1};
    vecs[4] = '{1, 3, 1, 2, 70, 30, 1};

    rst_n           = 1'b0;
    cfg_valid       = 1'b0;
    cfg_half_period = '0;
    cfg_on_ticks    = '0;
    cfg_off_ticks   = '0;
    cfg_beeps       = '0;
    start           = 1'b0;
    stop            = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tone", int'(tone_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tone", int'(tone_out), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(cfg_ready), 1);

    // Table vectors: cfg loaded in the same cycle as start.
    for (int i = 0; i < 5; i++) begin
      start_burst(1'b1, vecs[i].hp, vecs[i].on,
                  vecs[i].off, vecs[i].nb);
      watch(eff(vecs[i].hp), eff(vecs[i].on), vecs[i].off,
            vecs[i].nb, 0, -1, bn, rs, dn);
      check("vec_busy_len", bn, vecs[i].exp_busy);
      check("vec_rises", rs, vecs[i].exp_rises);
      check("vec_dones", dn, vecs[i].exp_dones);
      @(negedge clk);
    end

    // Random bursts, cfg sometimes loaded ahead of start.
    for (int i = 0; i < 8; i++) begin
      hp  = int'($urandom_range(0, 6));
      on  = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 2));
      nb  = int'($urandom_range(1, 3));
      check("rnd_ready", int'(cfg_ready), 1);
      if ($urandom_range(0, 1) == 1) begin
        cfg_half_period = 24'(hp);
        cfg_on_ticks    = 16'(on);
        cfg_off_ticks   = 16'(off);
        cfg_beeps       = 8'(nb);
        cfg_valid       = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start_burst(1'b0, 9, 9, 9, 9);
      end else begin
        start_burst(1'b1, hp, on, off, nb);
      end
      watch(eff(hp), eff(on), off, nb, 0, -1, bn, rs, dn);
      check("rnd_dones", dn, 1);
    end

    // Continuous tone, then stop.
    start_burst(1'b1, 2, 1, 1, 0);
    watch(2, 1, 1, 0, 1200, -1, bn, rs, dn);
    check("cont_busy", bn, 1200);
    check("cont_dones", dn, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_tone", int'(tone_out), 0);
    check("stop_done", int'(done), 0);
    check("stop_ready", int'(cfg_ready), 1);
    @(negedge clk);
    check("stop_done2", int'(done), 0);

    // Cfg and start offered while busy must be ignored.
    start_burst(1'b1, 2, 2, 0, 1);
    watch(2, 2, 0, 1, 0, 4, bn, rs, dn);
    check("busy_len", bn, 20);
    start_burst(1'b0, 5, 5, 5, 5);
    watch(2, 2, 0, 1, 0, -1, bn, rs, dn);
    check("kept_len", bn, 20);
    check("kept_rises", rs, 5);

    // start together with stop in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", int'(busy), 0);
    check("ss_tone", int'(tone_out), 0);
    @(negedge clk);
    check("ss_busy2", int'(busy), 0);

    // Async reset in the middle of an ON window.
    start_burst(1'b1, 1, 5, 0, 1);
    repeat (3) @(negedge clk);
    check("pre_rst_tone", int'(tone_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tone", int'(tone_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_done2", int'(done), 0);
    // Reset cfg: hp=1000/880=1, on=1, off=0, beeps=1.
    start_burst(1'b0, 4, 4, 4, 4);
    watch(1, 1, 0, 1, 0, -1, bn, rs, dn);
    check("rstcfg_len", bn, 10);
    check("rstcfg_rises", rs, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
